// File: rtl/fetch_mem_router.sv
// fetch_mem_router: routes icache line refills to the boot ROM or the L2, one at a time, with kill, timeout and spurious-response handling.
//   ic_req_*   : refill request from the icache (paddr latched on accept, ready only in IDLE)
//   ic_kill_i  : discard the pending refill
//   ic_resp_*  : registered single-cycle refill response; error marks a timeout with zero data
//   brom_*     : boot ROM valid/ready request and response
//   l2_*       : L2 single-cycle request pulse and response
//   spurious_resp_o : sticky flag for responses that arrive when none is expected
module fetch_mem_router #(
  parameter int PADDR_WIDTH = 40,
  parameter int LINE_WIDTH = 128,
  parameter int BROM_ADDR_WIDTH = 24,
  parameter logic [PADDR_WIDTH-1:0] BROM_BASE = '0,
  parameter int BROM_SIZE_LOG2 = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       ic_req_valid_i,
  input  logic [PADDR_WIDTH-1:0]     ic_req_paddr_i,
  output logic                       ic_req_ready_o,
  input  logic                       ic_kill_i,
  output logic                       ic_resp_valid_o,
  output logic [LINE_WIDTH-1:0]      ic_resp_data_o,
  output logic                       ic_resp_error_o,
  output logic                       brom_req_valid_o,
  output logic [BROM_ADDR_WIDTH-1:0] brom_req_address_o,
  input  logic                       brom_ready_i,
  input  logic                       brom_resp_valid_i,
  input  logic [LINE_WIDTH-1:0]      brom_resp_data_i,
  output logic                       l2_req_valid_o,
  output logic [PADDR_WIDTH-1:0]     l2_req_paddr_o,
  input  logic                       l2_resp_valid_i,
  input  logic [LINE_WIDTH-1:0]      l2_resp_data_i,
  output logic                       spurious_resp_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, BROM_REQ, BROM_WAIT, L2_WAIT, DRAIN} state_e;
  state_e state_q, state_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LINE_WIDTH-1:0] resp_data_q, resp_data_d;
  logic resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic l2_req_valid_q, l2_req_valid_d, spurious_q, spurious_d;
  logic src_brom_q, src_brom_d;
  logic is_brom, exp_brom, exp_l2, brom_hit, l2_hit, hit, expired;
  always_comb begin
    is_brom = (ic_req_paddr_i >> BROM_SIZE_LOG2) == (BROM_BASE >> BROM_SIZE_LOG2);
    // DRAIN remembers which source still owes a response
    exp_brom = state_q == BROM_WAIT || (state_q == DRAIN && src_brom_q);
    exp_l2 = state_q == L2_WAIT || (state_q == DRAIN && !src_brom_q);
    brom_hit = brom_resp_valid_i && exp_brom;
    l2_hit = l2_resp_valid_i && exp_l2;
    hit = brom_hit || l2_hit;
    expired = timer_q == T_MAX;
    state_d = state_q;
    paddr_d = paddr_q;
    src_brom_d = src_brom_q;
    l2_req_valid_d = 1'b0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_data_d = resp_data_q;
    spurious_d = spurious_q || (brom_resp_valid_i && !exp_brom) || (l2_resp_valid_i && !exp_l2);
    case (state_q)
      IDLE: if (ic_req_valid_i) begin
        paddr_d = ic_req_paddr_i;
        src_brom_d = is_brom;
        l2_req_valid_d = !is_brom;
        state_d = is_brom ? BROM_REQ : L2_WAIT;
      end
      BROM_REQ: if (brom_ready_i) state_d = ic_kill_i ? DRAIN : BROM_WAIT;
        else if (ic_kill_i) state_d = IDLE;
      BROM_WAIT, L2_WAIT: if (ic_kill_i) state_d = hit ? IDLE : DRAIN;
        else if (hit || expired) begin
          // a response in the expiry cycle still wins over the timeout
          state_d = IDLE;
          resp_valid_d = 1'b1;
          resp_error_d = !hit;
          resp_data_d = !hit ? '0 : brom_hit ? brom_resp_data_i : l2_resp_data_i;
        end
      DRAIN: if (hit || expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // cleared on entry, saturating while staying in a waiting state
    timer_d = (state_q inside {BROM_WAIT, L2_WAIT, DRAIN} && state_d == state_q) ?
      (expired ? timer_q : timer_q + TW'(1)) : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      paddr_q <= '0;
      src_brom_q <= 1'b0;
      timer_q <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q <= '0;
      l2_req_valid_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      src_brom_q <= src_brom_d;
      timer_q <= timer_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q <= resp_data_d;
      l2_req_valid_q <= l2_req_valid_d;
      spurious_q <= spurious_d;
    end
  end
  assign ic_req_ready_o = state_q == IDLE;
  assign ic_resp_valid_o = resp_valid_q;
  assign ic_resp_error_o = resp_error_q;
  assign ic_resp_data_o = resp_data_q;
  assign brom_req_valid_o = state_q == BROM_REQ;
  assign brom_req_address_o = paddr_q[BROM_ADDR_WIDTH-1:0];
  assign l2_req_valid_o = l2_req_valid_q;
  assign l2_req_paddr_o = paddr_q;
  assign spurious_resp_o = spurious_q;
endmodule

// File: tb/tb_fetch_mem_router.sv
// tb_fetch_mem_router: randomized scoreboard bench for fetch_mem_router.
module tb_fetch_mem_router;
  localparam int PW = 40, LW = 128, BW = 24, T = 8;
  logic clk = 0, rstn = 0;
  logic ic_req_valid = 0, ic_kill = 0, brom_ready = 0, brom_resp_valid = 0, l2_resp_valid = 0;
  logic [PW-1:0] ic_req_paddr = '0;
  logic [LW-1:0] brom_resp_data = '0, l2_resp_data = '0;
  logic ic_req_ready, ic_resp_valid, ic_resp_error, brom_req_valid, l2_req_valid, spurious;
  logic [LW-1:0] ic_resp_data;
  logic [BW-1:0] brom_req_address;
  logic [PW-1:0] l2_req_paddr;
  typedef struct {logic [LW-1:0] d; logic e; int c;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, passed = 0, l2_exp = 0, l2_seen = 0, cyc = 0;
  fetch_mem_router #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ic_req_valid_i(ic_req_valid), .ic_req_paddr_i(ic_req_paddr), .ic_req_ready_o(ic_req_ready),
    .ic_kill_i(ic_kill),
    .ic_resp_valid_o(ic_resp_valid), .ic_resp_data_o(ic_resp_data), .ic_resp_error_o(ic_resp_error),
    .brom_req_valid_o(brom_req_valid), .brom_req_address_o(brom_req_address), .brom_ready_i(brom_ready),
    .brom_resp_valid_i(brom_resp_valid), .brom_resp_data_i(brom_resp_data),
    .l2_req_valid_o(l2_req_valid), .l2_req_paddr_o(l2_req_paddr),
    .l2_resp_valid_i(l2_resp_valid), .l2_resp_data_i(l2_resp_data),
    .spurious_resp_o(spurious)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  always @(negedge clk) if (rstn) begin
    if (l2_req_valid) l2_seen++;
    if (ic_resp_valid) begin
      if (sb.size() == 0) chk("resp_unexpected", ic_resp_valid, 1'b0);
      else begin
        mon_e = sb.pop_front();
        chk("resp_data", ic_resp_data, mon_e.d);
        chk("resp_error", ic_resp_error, mon_e.e);
        chk("resp_cycle", cyc, mon_e.c);
      end
    end
  end
  task automatic chk_reset();
    chk("rst_resp_valid", ic_resp_valid, 0);
    chk("rst_resp_data", ic_resp_data, 0);
    chk("rst_resp_error", ic_resp_error, 0);
    chk("rst_brom_valid", brom_req_valid, 0);
    chk("rst_brom_addr", brom_req_address, 0);
    chk("rst_l2_valid", l2_req_valid, 0);
    chk("rst_l2_paddr", l2_req_paddr, 0);
    chk("rst_spurious", spurious, 0);
    chk("rst_ready", ic_req_ready, 1);
  endtask
  // rdy: cycles before brom ready; kpre: kill index during the ROM handshake (-1 none);
  // rsp: response index in the wait phase (-1 never); kat: kill index in the wait phase (-1 none)
  task automatic txn(input logic [PW-1:0] pa, input int rdy, input int kpre, input int rsp,
                     input int kat, input logic [LW-1:0] d, input bit both);
    bit br;
    int c0, base, stop;
    br = pa < 40'h1_0000;
    c0 = cyc;
    base = br ? 2 + rdy : 1;
    if (kpre < 0 && kat < 0) begin
      if (rsp >= 0) sb.push_back('{d, 1'b0, c0 + base + rsp + 1});
      else sb.push_back('{'0, 1'b1, c0 + base + T});
    end
    if (!br) l2_exp++;
    ic_req_valid = 1;
    ic_req_paddr = pa;
    @(posedge clk); #1;
    ic_req_valid = 0;
    ic_req_paddr = '0;
    if (br) begin
      for (int j = 0; j <= rdy; j++) begin
        chk("brom_valid", brom_req_valid, 1);
        chk("brom_addr", brom_req_address, pa[BW-1:0]);
        brom_ready = j == rdy;
        ic_kill = j == kpre;
        @(posedge clk); #1;
        brom_ready = 0;
        ic_kill = 0;
        if (j == kpre) begin
          chk("ready_after_kill", ic_req_ready, 1);
          return;
        end
      end
    end else begin
      chk("l2_valid", l2_req_valid, 1);
      chk("l2_paddr", l2_req_paddr, pa);
    end
    stop = rsp >= 0 ? rsp : (kat >= 0 ? kat + T : T - 1);
    for (int i = 0; i <= stop; i++) begin
      chk("busy", ic_req_ready, 0);
      if (i == rsp) begin
        if (br || both) begin brom_resp_valid = 1; brom_resp_data = br ? d : ~d; end
        if (!br || both) begin l2_resp_valid = 1; l2_resp_data = br ? ~d : d; end
      end
      ic_kill = i == kat;
      @(posedge clk); #1;
      brom_resp_valid = 0;
      l2_resp_valid = 0;
      ic_kill = 0;
    end
    chk("ready_done", ic_req_ready, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
  initial begin
    bit br;
    int rdy, kpre, rsp, kat;
    logic [PW-1:0] pa;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rstn = 1;
    @(posedge clk); #1;
    txn(40'h100, 2, -1, 3, -1, {16{8'hA5}}, 0);
    txn(40'h80_0000_40, 0, -1, 5, -1, 128'h1234, 0);
    txn(40'h80_0000_80, 0, -1, 5, 2, 128'hdead, 0);
    txn(40'h80_0000_c0, 0, -1, -1, -1, 128'hbeef, 0);
    txn(40'h80_0001_00, 0, -1, 0, -1, 128'h5555, 0);
    txn(40'h00_0000_ffff, 1, -1, 1, -1, 128'h77, 0);
    txn(40'h00_0001_0000, 0, -1, 2, -1, 128'h88, 0);
    txn(40'h200, 3, 1, 0, -1, 128'h99, 0);
    txn(40'h300, 1, -1, 4, 4, 128'haa, 0);
    txn(40'h400, 0, -1, -1, 3, 128'hbb, 0);
    chk("spurious_clean", spurious, 0);
    for (int n = 0; n < 40; n++) begin
      br = 1'($urandom_range(0, 1));
      pa = br ? PW'($urandom_range(0, 16'hFFFF)) : {8'h0, 1'b1, 31'($urandom)};
      rdy = int'($urandom_range(0, 3));
      kpre = (br && rdy > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, rdy - 1)) : -1;
      rsp = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, T - 1));
      kat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rsp >= 0 ? rsp : T - 1)) : -1;
      txn(pa, rdy, kpre, rsp, kat, {$urandom, $urandom, $urandom, $urandom}, 0);
    end
    chk("spurious_after_random", spurious, 0);
    brom_resp_valid = 1;
    brom_resp_data = {4{32'hcafe}};
    @(posedge clk); #1;
    brom_resp_valid = 0;
    chk("spurious_idle", spurious, 1);
    txn(40'h80_0000_1000, 0, -1, 2, -1, 128'h600d, 1);
    chk("spurious_both", spurious, 1);
    ic_req_valid = 1;
    ic_req_paddr = 40'h500;
    @(posedge clk); #1;
    ic_req_valid = 0;
    brom_ready = 1;
    @(posedge clk); #1;
    brom_ready = 0;
    @(posedge clk); #1;
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    chk_reset();
    brom_resp_valid = 1;
    @(posedge clk); #1;
    brom_resp_valid = 0;
    chk("spurious_late", spurious, 1);
    chk("ready_late", ic_req_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("l2_pulses", l2_seen, l2_exp);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
